// File: rtl/rvv_cmd_queue_ctrl_pkg.sv
// Shared types and helpers for the RVV command queue and its front end.
// Holds the RVV command record plus the popcount and prefix-shape helpers.
package rvv_cmd_queue_ctrl_pkg;

  typedef struct packed {
    logic [6:0] funct;
    logic [4:0] vd;
    logic [4:0] vs1;
    logic [4:0] vs2;
    logic [9:0] tag;
  } rvv_cmd_t;

  // Widest lane vector the helpers accept; callers zero-extend into it.
  localparam int unsigned MaxVecW = 32;

  function automatic int unsigned popcount(input logic [MaxVecW-1:0] vec);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < MaxVecW; i++) begin
      cnt += {31'b0, vec[i]};
    end
    return cnt;
  endfunction

  // True when the set bits form a contiguous run starting at bit 0.
  function automatic logic is_prefix(input logic [MaxVecW-1:0] vec);
    return (vec & (vec + MaxVecW'(1))) == '0;
  endfunction

endpackage

// File: rtl/rvv_cmd_queue_ctrl_if.sv
// Handshake bundle between the front end / dispatch and the RVV command queue.
// The slave modport is the queue; the master modport is the producer and consumer side.
interface rvv_cmd_queue_ctrl_if
  import rvv_cmd_queue_ctrl_pkg::*;
#(
  parameter int unsigned N            = 4,
  parameter int unsigned M            = 2,
  parameter int unsigned CAPACITYBITS = 4
);

  logic [N-1:0]            accept_i;
  logic [N-1:0]            enq_valid_i;
  rvv_cmd_t [N-1:0]        enq_data_i;
  logic [CAPACITYBITS-1:0] capacity_o;
  logic [M-1:0]            deq_valid_o;
  rvv_cmd_t [M-1:0]        deq_data_o;
  logic [M-1:0]            deq_ready_i;
  logic                    flush_i;
  logic [CAPACITYBITS-1:0] count_o;

  modport slave (
    input  accept_i, enq_valid_i, enq_data_i, deq_ready_i, flush_i,
    output capacity_o, deq_valid_o, deq_data_o, count_o
  );

  modport master (
    output accept_i, enq_valid_i, enq_data_i, deq_ready_i, flush_i,
    input  capacity_o, deq_valid_o, deq_data_o, count_o
  );

endinterface

// File: rtl/rvv_cmd_queue_ctrl_storage.sv
// Circular command storage with N write lanes and M read lanes.
// Addresses wrap modulo DEPTH; contents are intentionally not reset.
module rvv_cmd_queue_ctrl_storage
  import rvv_cmd_queue_ctrl_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned M     = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic [N-1:0]               wr_en_i,
  input  logic [$clog2(DEPTH)-1:0]   wr_ptr_i,
  input  rvv_cmd_t [N-1:0]           wr_data_i,
  input  logic [$clog2(DEPTH)-1:0]   rd_ptr_i,
  output rvv_cmd_t [M-1:0]           rd_data_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  rvv_cmd_t         mem_q [DEPTH];
  logic [PtrW-1:0]  wr_idx [N];
  logic [PtrW-1:0]  rd_idx [M];

  // Pointer sums truncate to PtrW bits, which is the modulo-DEPTH wrap.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      wr_idx[k] = wr_ptr_i + PtrW'(k);
    end
    for (int j = 0; j < M; j++) begin
      rd_idx[j] = rd_ptr_i + PtrW'(j);
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (wr_en_i[k]) begin
        mem_q[wr_idx[k]] <= wr_data_i[k];
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int j = 0; j < M; j++) begin
      rd_data_o[j] = mem_q[rd_idx[j]];
    end
  end

endmodule

// File: rtl/rvv_cmd_queue_ctrl.sv
// Multi-port RVV command queue with credit tracking for the front end.
// Capacity reserves slots for last cycle's acceptances that have not been enqueued yet.
module rvv_cmd_queue_ctrl
  import rvv_cmd_queue_ctrl_pkg::*;
#(
  parameter int unsigned N            = 4,
  parameter int unsigned M            = 2,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned CAPACITYBITS = $clog2(DEPTH + 1)
) (
  input logic                 clk,
  input logic                 rstn,
  rvv_cmd_queue_ctrl_if.slave bus
);

  localparam int unsigned PtrW      = $clog2(DEPTH);
  localparam int unsigned CountBits = $clog2(N + 1);
  localparam int unsigned DeqBits   = $clog2(M + 1);

  typedef logic [PtrW-1:0]         ptr_t;
  typedef logic [CAPACITYBITS-1:0] cnt_t;
  typedef logic [CAPACITYBITS:0]   wide_t;

  ptr_t                 rd_ptr_q, rd_ptr_d;
  ptr_t                 wr_ptr_q, wr_ptr_d;
  cnt_t                 count_q, count_d;
  logic [CountBits-1:0] inflight_q, inflight_d;
  logic [CountBits-1:0] enq_n, accept_n;
  logic [DeqBits-1:0]   deq_n;
  logic [M-1:0]         deq_valid, deq_fire;
  logic [N-1:0]         wr_en;
  wide_t                reserved;
  rvv_cmd_t [M-1:0]     rd_data;

  always_comb begin
    deq_valid = '0;
    for (int j = 0; j < M; j++) begin
      deq_valid[j] = cnt_t'(j) < count_q;
    end
    deq_fire = deq_valid & bus.deq_ready_i;
    enq_n    = CountBits'(popcount(MaxVecW'(bus.enq_valid_i)));
    accept_n = CountBits'(popcount(MaxVecW'(bus.accept_i)));
    deq_n    = DeqBits'(popcount(MaxVecW'(deq_fire)));
    wr_en    = bus.flush_i ? '0 : bus.enq_valid_i;
    reserved = wide_t'(count_q) + wide_t'(inflight_q);
  end

  // Flush discards this cycle's traffic as well as everything already held.
  always_comb begin
    rd_ptr_d   = '0;
    wr_ptr_d   = '0;
    count_d    = '0;
    inflight_d = '0;
    if (!bus.flush_i) begin
      rd_ptr_d   = rd_ptr_q + ptr_t'(deq_n);
      wr_ptr_d   = wr_ptr_q + ptr_t'(enq_n);
      count_d    = count_q + cnt_t'(enq_n) - cnt_t'(deq_n);
      inflight_d = accept_n;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end

  rvv_cmd_queue_ctrl_storage #(
    .N     (N),
    .M     (M),
    .DEPTH (DEPTH)
  ) u_storage (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_ptr_i  (wr_ptr_q),
    .wr_data_i (bus.enq_data_i),
    .rd_ptr_i  (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  // Register-only capacity; same-cycle dequeues free slots only from the next cycle.
  always_comb begin
    bus.capacity_o  = (reserved >= wide_t'(DEPTH)) ? '0 : cnt_t'(wide_t'(DEPTH) - reserved);
    bus.count_o     = count_q;
    bus.deq_valid_o = deq_valid;
    bus.deq_data_o  = rd_data;
  end

`ifndef SYNTHESIS
  a_enq_le_inflight: assert property (@(posedge clk) disable iff (!rstn)
    enq_n <= inflight_q);
  a_enq_prefix: assert property (@(posedge clk) disable iff (!rstn)
    is_prefix(MaxVecW'(bus.enq_valid_i)));
  a_ready_prefix: assert property (@(posedge clk) disable iff (!rstn)
    is_prefix(MaxVecW'(bus.deq_ready_i)));
  a_no_overcommit: assert property (@(posedge clk) disable iff (!rstn)
    reserved <= wide_t'(DEPTH));
  a_accept_le_capacity: assert property (@(posedge clk) disable iff (!rstn)
    wide_t'(accept_n) <= wide_t'(bus.capacity_o));
`endif

endmodule

// File: tb/tb_rvv_cmd_queue_ctrl.sv
// Self-checking bench: a queue-based model of the command queue checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with flushes.
module tb_rvv_cmd_queue_ctrl;
  import rvv_cmd_queue_ctrl_pkg::*;

  localparam int unsigned N     = 4;
  localparam int unsigned M     = 2;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CB    = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  rvv_cmd_queue_ctrl_if #(.N(N), .M(M), .CAPACITYBITS(CB)) bus ();

  rvv_cmd_queue_ctrl #(
    .N            (N),
    .M            (M),
    .DEPTH        (DEPTH),
    .CAPACITYBITS (CB)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  rvv_cmd_t mq[$];
  int       inflight_m = 0;
  int       n_checks   = 0;
  int       n_errors   = 0;
  int       seq        = 0;
  bit       check_on   = 1'b0;
  bit       wrap_mode  = 1'b0;
  int       wrap_exp   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cap_m();
    int c;
    c = int'(DEPTH) - mq.size() - inflight_m;
    return (c < 0) ? 0 : c;
  endfunction

  // Every cycle, away from the active edge, the registered outputs must match the model.
  always @(negedge clk) begin
    if (rstn && check_on) begin
      chk("capacity", 64'(bus.capacity_o), 64'(cap_m()));
      chk("count", 64'(bus.count_o), 64'(mq.size()));
      for (int j = 0; j < M; j++) begin
        chk("deq_valid", 64'(bus.deq_valid_o[j]), 64'(j < mq.size()));
        if (j < mq.size()) begin
          chk("deq_data", {32'b0, bus.deq_data_o[j]}, {32'b0, mq[j]});
        end
      end
    end
  end

  // One clock of traffic: acc accepts, enq prefix enqueues, rdy prefix ready, optional flush.
  task automatic cyc(input int acc, input int enq, input int rdy, input bit fl);
    rvv_cmd_t newc [N];
    int       dn;
    for (int k = 0; k < N; k++) begin
      newc[k] = rvv_cmd_t'($urandom);
      if (k < enq) begin
        newc[k].tag = 10'(seq);
        seq++;
      end
      bus.enq_data_i[k] = newc[k];
    end
    bus.accept_i    = N'((1 << acc) - 1);
    bus.enq_valid_i = N'((1 << enq) - 1);
    bus.deq_ready_i = M'((1 << rdy) - 1);
    bus.flush_i     = fl;
    dn = (rdy < mq.size()) ? rdy : mq.size();
    if (wrap_mode && !fl) begin
      for (int j = 0; j < dn; j++) begin
        chk("wrap_order", {54'b0, bus.deq_data_o[j].tag}, 64'(wrap_exp));
        wrap_exp++;
      end
    end
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete();
      inflight_m = 0;
    end else begin
      repeat (dn) void'(mq.pop_front());
      for (int k = 0; k < enq; k++) mq.push_back(newc[k]);
      inflight_m = acc;
    end
  endtask

  task automatic idle_inputs();
    bus.accept_i    = '0;
    bus.enq_valid_i = '0;
    bus.enq_data_i  = '0;
    bus.deq_ready_i = '0;
    bus.flush_i     = 1'b0;
  endtask

  initial begin
    int guard;
    idle_inputs();
    #1 rstn = 1'b0;
    #1;
    chk("reset_capacity", 64'(bus.capacity_o), 64'd8);
    chk("reset_count", 64'(bus.count_o), 64'd0);
    chk("reset_deq_valid", 64'(bus.deq_valid_o), 64'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    check_on = 1'b1;

    // Credit reservation and setvl release.
    cyc(4, 0, 0, 0);
    chk("cap_after_accept4", 64'(bus.capacity_o), 64'd4);
    cyc(0, 3, 0, 0);
    chk("count_after_enq3", 64'(bus.count_o), 64'd3);
    chk("cap_after_enq3", 64'(bus.capacity_o), 64'd5);
    chk("deq_valid_after_enq3", 64'(bus.deq_valid_o), 64'd3);
    chk("head0_tag", {54'b0, bus.deq_data_o[0].tag}, 64'd0);
    chk("head1_tag", {54'b0, bus.deq_data_o[1].tag}, 64'd1);

    // Fill to full, then drain two.
    cyc(4, 0, 0, 0);
    cyc(1, 4, 0, 0);
    cyc(0, 1, 0, 0);
    chk("full_count", 64'(bus.count_o), 64'd8);
    chk("full_capacity", 64'(bus.capacity_o), 64'd0);
    chk("full_deq_valid", 64'(bus.deq_valid_o), 64'd3);
    cyc(0, 0, 2, 0);
    chk("drain_count", 64'(bus.count_o), 64'd6);
    chk("drain_capacity", 64'(bus.capacity_o), 64'd2);

    // Simultaneous enqueue 1 / dequeue 2 from count 7.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    chk("count7", 64'(bus.count_o), 64'd7);
    chk("count7_head", {54'b0, bus.deq_data_o[0].tag}, 64'd2);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 2, 0);
    chk("simul_count", 64'(bus.count_o), 64'd6);
    chk("simul_head", {54'b0, bus.deq_data_o[0].tag}, 64'd4);

    // Flush with count 5 and three in flight.
    cyc(0, 0, 1, 0);
    cyc(3, 0, 0, 0);
    chk("preflush_capacity", 64'(bus.capacity_o), 64'd0);
    cyc(0, 2, 2, 1);
    chk("flush_count", 64'(bus.count_o), 64'd0);
    chk("flush_capacity", 64'(bus.capacity_o), 64'd8);
    chk("flush_deq_valid", 64'(bus.deq_valid_o), 64'd0);
    cyc(2, 0, 0, 0);
    cyc(3, 2, 0, 1);
    chk("flush_drops_accept", 64'(bus.capacity_o), 64'd8);

    // Wrap-around: sequence numbers 0..31 must come out in order.
    seq       = 0;
    wrap_exp  = 0;
    wrap_mode = 1'b1;
    guard     = 0;
    while ((seq < 32 || inflight_m > 0 || mq.size() > 0) && guard < 300) begin
      int a;
      a = cap_m();
      if (a > int'(N)) a = N;
      if (a > 32 - seq - inflight_m) a = 32 - seq - inflight_m;
      cyc(a, inflight_m, 2, 0);
      guard++;
    end
    wrap_mode = 1'b0;
    chk("wrap_total", 64'(wrap_exp), 64'd32);

    // Asynchronous reset in the middle of filling.
    cyc(4, 0, 0, 0);
    cyc(4, 4, 0, 0);
    idle_inputs();
    #3 rstn = 1'b0;
    #1;
    chk("areset_count", 64'(bus.count_o), 64'd0);
    chk("areset_capacity", 64'(bus.capacity_o), 64'd8);
    chk("areset_deq_valid", 64'(bus.deq_valid_o), 64'd0);
    mq.delete();
    inflight_m = 0;
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 0);
    chk("post_reset_capacity", 64'(bus.capacity_o), 64'd8);

    // Randomized traffic with setvl drops and occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      int a, e, r;
      bit f;
      a = cap_m();
      if (a > int'(N)) a = N;
      a = int'($urandom_range(a, 0));
      e = int'($urandom_range(inflight_m, 0));
      if ($urandom_range(3, 0) != 0) e = inflight_m;
      r = int'($urandom_range(M, 0));
      f = ($urandom_range(31, 0) == 0);
      cyc(a, e, r, f);
    end

    idle_inputs();
    @(negedge clk);
    check_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
